// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter slice.
// Port identifiers, FSM encodings and bus widths.
package dmem_arbiter_pkg;

    localparam int WORD_SIZE   = 32;
    localparam int DMEM_ADDR_W = WORD_SIZE;
    localparam int DMEM_DATA_W = WORD_SIZE;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam logic [0:0] ARB_S    = 1'b0;
    localparam logic [0:0] LOCKED_S = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and data_mem.
// slave = arbiter view, master = requester/memory view.
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_lock;

    logic              mem_write;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_write, mem_read, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_write, mem_read, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_starve_cnt.sv
// Saturating count of CPU grants taken while the debug port waits.
// at_max hands the next slot to the debug port.
module dmem_starve_cnt #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);
    localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);

    logic [W-1:0] cnt;

    assign at_max = (cnt == W'(MAX));

    // Clear wins over increment; hold once saturated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !at_max)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares single-port data_mem between the CPU MEM stage and debug.
// CPU has priority, bounded by a starvation counter; debug may lock.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DMEM_ADDR_W,
    parameter int DATA_W     = DMEM_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic              cpu_win;
    logic              dbg_win;
    logic              any_win;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              at_max;
    logic              rd_pend;
    logic              rd_owner;

    dmem_starve_cnt #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .rst    (rst),
        .inc    (cpu_win & bus.dbg_req),
        .clr    (dbg_win | ~bus.dbg_req),
        .at_max (at_max)
    );

    // Pick at most one winner; nothing is granted while in reset.
    always_comb begin
        cpu_win = 1'b0;
        dbg_win = 1'b0;
        if (!rst) begin
            if (state == LOCKED_S) begin
                dbg_win = bus.dbg_req;
            end else begin
                dbg_win = bus.dbg_req & (~bus.cpu_req | at_max);
                cpu_win = bus.cpu_req & ~dbg_win;
            end
        end
    end

    // Route the winner's command; idle bus is all zeros.
    always_comb begin
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        unique case (1'b1)
            cpu_win: begin
                win_we    = bus.cpu_we;
                win_addr  = bus.cpu_addr;
                win_wdata = bus.cpu_wdata;
            end
            dbg_win: begin
                win_we    = bus.dbg_we;
                win_addr  = bus.dbg_addr;
                win_wdata = bus.dbg_wdata;
            end
            default: ;
        endcase
    end

    assign any_win       = cpu_win | dbg_win;
    assign bus.cpu_gnt   = cpu_win;
    assign bus.dbg_gnt   = dbg_win;
    assign bus.mem_write = any_win & win_we;
    assign bus.mem_read  = any_win & ~win_we;
    assign bus.mem_addr  = win_addr;
    assign bus.mem_wdata = win_wdata;

    // Lock is entered by a locked debug grant, left when lock drops.
    always_comb begin
        state_nxt = state;
        if (state == LOCKED_S) begin
            if (!bus.dbg_lock)
                state_nxt = ARB_S;
        end else if (dbg_win && bus.dbg_lock) begin
            state_nxt = LOCKED_S;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ARB_S;
        else
            state <= state_nxt;
    end

    // Remember who issued a read so next-cycle data goes back to it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend  <= 1'b0;
            rd_owner <= PORT_CPU;
        end else begin
            rd_pend  <= any_win & ~win_we;
            rd_owner <= dbg_win ? PORT_DBG : PORT_CPU;
        end
    end

    assign bus.cpu_rvalid = rd_pend & (rd_owner == PORT_CPU);
    assign bus.dbg_rvalid = rd_pend & (rd_owner == PORT_DBG);
    assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : '0;
    assign bus.dbg_rdata  = bus.dbg_rvalid ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small data_mem model.
// Inputs change on negedge; outputs are checked 1ns later.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [31:0] mem [0:15];

    dmem_arbiter_if bus ();

    dmem_arbiter #(
        .STARVE_MAX (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // data_mem model: registered read, write at the closing posedge.
    always @(posedge clk) begin
        if (bus.mem_read)
            bus.mem_rdata <= mem[bus.mem_addr[3:0]];
        if (bus.mem_write)
            mem[bus.mem_addr[3:0]] <= bus.mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic setc(input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
        bus.cpu_req   = r;
        bus.cpu_we    = w;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
    endtask

    task automatic setd(input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic l);
        bus.dbg_req   = r;
        bus.dbg_we    = w;
        bus.dbg_addr  = a;
        bus.dbg_wdata = d;
        bus.dbg_lock  = l;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.mem_rdata = '0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[1] = 32'h11;
        mem[2] = 32'h22;
        mem[5] = 32'hDEADBEEF;
        setc(1'b1, 1'b0, 32'd5, 32'd0);
        setd(1'b1, 1'b0, 32'd3, 32'd0, 1'b0);

        // reset state: requests present, nothing granted
        @(negedge clk); #1;
        chk("rst_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
        chk("rst_dbg_gnt", 32'(bus.dbg_gnt), 32'd0);
        chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);

        @(negedge clk);
        rst = 1'b0;
        setc(1'b0, 1'b0, 32'd0, 32'd0);
        setd(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

        // CPU read of addr 5
        @(negedge clk);
        setc(1'b1, 1'b0, 32'd5, 32'd0);
        #1;
        chk("rd_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
        chk("rd_mem_read", 32'(bus.mem_read), 32'd1);
        chk("rd_mem_write", 32'(bus.mem_write), 32'd0);
        chk("rd_mem_addr", bus.mem_addr, 32'd5);
        @(negedge clk);
        setc(1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        chk("rd_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
        chk("rd_cpu_rdata", bus.cpu_rdata, 32'hDEADBEEF);
        chk("rd_dbg_rvalid", 32'(bus.dbg_rvalid), 32'd0);
        chk("rd_dbg_rdata", bus.dbg_rdata, 32'd0);
        chk("rd_idle_mem_read", 32'(bus.mem_read), 32'd0);

        // back-to-back CPU reads at 1 and 2
        @(negedge clk);
        setc(1'b1, 1'b0, 32'd1, 32'd0);
        #1;
        chk("pipe_gnt0", 32'(bus.cpu_gnt), 32'd1);
        chk("pipe_rv0", 32'(bus.cpu_rvalid), 32'd0);
        @(negedge clk);
        setc(1'b1, 1'b0, 32'd2, 32'd0);
        #1;
        chk("pipe_gnt1", 32'(bus.cpu_gnt), 32'd1);
        chk("pipe_rv1", 32'(bus.cpu_rvalid), 32'd1);
        chk("pipe_data1", bus.cpu_rdata, 32'h11);
        @(negedge clk);
        setc(1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        chk("pipe_rv2", 32'(bus.cpu_rvalid), 32'd1);
        chk("pipe_data2", bus.cpu_rdata, 32'h22);
        @(negedge clk); #1;
        chk("pipe_rv3", 32'(bus.cpu_rvalid), 32'd0);

        // dbg read in T, cpu write in T+1
        @(negedge clk);
        setd(1'b1, 1'b0, 32'd5, 32'd0, 1'b0);
        #1;
        chk("il_dbg_gnt", 32'(bus.dbg_gnt), 32'd1);
        chk("il_cpu_gnt0", 32'(bus.cpu_gnt), 32'd0);
        @(negedge clk);
        setd(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        setc(1'b1, 1'b1, 32'd7, 32'h77);
        #1;
        chk("il_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
        chk("il_mem_write", 32'(bus.mem_write), 32'd1);
        chk("il_mem_wdata", bus.mem_wdata, 32'h77);
        chk("il_dbg_rvalid", 32'(bus.dbg_rvalid), 32'd1);
        chk("il_dbg_rdata", bus.dbg_rdata, 32'hDEADBEEF);
        chk("il_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        chk("il_cpu_rdata", bus.cpu_rdata, 32'd0);
        @(negedge clk);
        setc(1'b1, 1'b0, 32'd7, 32'd0);
        #1;
        chk("il_cpu_rvalid2", 32'(bus.cpu_rvalid), 32'd0);
        @(negedge clk);
        setc(1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        chk("il_wr_landed", bus.cpu_rdata, 32'h77);

        // contention: cpu x4, dbg x1, repeating
        @(negedge clk);
        setc(1'b1, 1'b1, 32'd8, 32'h88);
        setd(1'b1, 1'b1, 32'd9, 32'h99, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk($sformatf("ct_cpu_%0d", i), 32'(bus.cpu_gnt),
                (i % 5 == 4) ? 32'd0 : 32'd1);
            chk($sformatf("ct_dbg_%0d", i), 32'(bus.dbg_gnt),
                (i % 5 == 4) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        setc(1'b0, 1'b0, 32'd0, 32'd0);
        setd(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

        // lock: 4 dbg writes, cpu held off until lock drops
        @(negedge clk);
        setd(1'b1, 1'b1, 32'd10, 32'hA0, 1'b1);
        #1;
        chk("lk_dbg_gnt0", 32'(bus.dbg_gnt), 32'd1);
        @(negedge clk);
        setc(1'b1, 1'b1, 32'd14, 32'hCC);
        setd(1'b1, 1'b1, 32'd11, 32'hA1, 1'b1);
        #1;
        chk("lk_cpu_gnt1", 32'(bus.cpu_gnt), 32'd0);
        chk("lk_dbg_gnt1", 32'(bus.dbg_gnt), 32'd1);
        @(negedge clk);
        setd(1'b1, 1'b1, 32'd12, 32'hA2, 1'b1);
        #1;
        chk("lk_cpu_gnt2", 32'(bus.cpu_gnt), 32'd0);
        chk("lk_dbg_gnt2", 32'(bus.dbg_gnt), 32'd1);
        @(negedge clk);
        setd(1'b1, 1'b1, 32'd13, 32'hA3, 1'b0);
        #1;
        chk("lk_cpu_gnt3", 32'(bus.cpu_gnt), 32'd0);
        chk("lk_dbg_gnt3", 32'(bus.dbg_gnt), 32'd1);
        chk("lk_mem_addr3", bus.mem_addr, 32'd13);
        @(negedge clk);
        setd(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        #1;
        chk("lk_cpu_gnt4", 32'(bus.cpu_gnt), 32'd1);
        @(negedge clk);
        setc(1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            if (i < 5)
                setd(1'b1, 1'b0, 32'(10 + i), 32'd0, 1'b0);
            else
                setd(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
            #1;
            if (i > 0)
                chk($sformatf("lk_mem_%0d", 9 + i), bus.dbg_rdata,
                    (i == 5) ? 32'hCC : (32'hA0 + 32'(i - 1)));
        end

        // reset mid-read drops the pending return
        @(negedge clk);
        setc(1'b1, 1'b0, 32'd5, 32'd0);
        #1;
        chk("mr_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
        @(posedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("mr_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        chk("mr_cpu_gnt_rst", 32'(bus.cpu_gnt), 32'd0);
        chk("mr_mem_read", 32'(bus.mem_read), 32'd0);
        chk("mr_mem_addr", bus.mem_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mr_cpu_rvalid2", 32'(bus.cpu_rvalid), 32'd0);
        chk("mr_regrant", 32'(bus.cpu_gnt), 32'd1);
        @(negedge clk);
        setc(1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        chk("mr_rvalid3", 32'(bus.cpu_rvalid), 32'd1);
        chk("mr_rdata3", bus.cpu_rdata, 32'hDEADBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data memory (`data_mem`) between the CPU load/store stage and the debug/loader port. It sits between the MEM pipeline stage and `data_mem`. It issues at most one memory command per cycle and routes returned read data to the port that issued the read. The CPU has fixed priority, bounded by an anti-starvation counter, and the debug port can lock the memory for burst loads.

## Interface
Parameters:
- ADDR_W, 32, word address width (matches data_mem address)
- DATA_W, 32, data width
- STARVE_MAX, 4, maximum consecutive CPU grants while dbg_req is pending

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- cpu_req  in  1  CPU access request; held until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  word address
- cpu_wdata  in  DATA_W  write data
- cpu_gnt  out  1  request accepted this cycle
- cpu_rvalid  out  1  cpu_rdata valid (one cycle)
- cpu_rdata  out  DATA_W  read data
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: same as the cpu_* ports, for the debug port
- dbg_lock  in  1  while high after a dbg grant, memory is reserved for dbg
- mem_write  out  1  to data_mem write
- mem_read  out  1  to data_mem read
- mem_addr  out  ADDR_W  to data_mem address
- mem_wdata  out  DATA_W  to data_mem writeData
- mem_rdata  in  DATA_W  from data_mem dataOut

## Operation
- FSM has two states: ARB (reset state) and LOCKED.
- **ARB state:**
  - Grant dbg if dbg_req and (!cpu_req or starve_cnt == STARVE_MAX).
  - Otherwise grant cpu if cpu_req.
  - At most one gnt per cycle.
- **starve_cnt:**
  - Increments, saturating at STARVE_MAX, on each cpu grant while dbg_req = 1.
  - Clears on a dbg grant or whenever dbg_req = 0.
- **ARB -> LOCKED:** on a dbg grant with dbg_lock = 1.
- **LOCKED state:**
  - Only dbg is granted; cpu_gnt is held 0.
  - LOCKED -> ARB when dbg_lock = 0 (sampled each cycle). An access granted in that same cycle completes normally.
- **Memory command:**
  - In the grant cycle, mem_addr and mem_wdata are taken combinationally from the winning port.
  - mem_write = gnt & we; mem_read = gnt & !we.
  - With no grant: mem_write = mem_read = 0, and mem_addr/mem_wdata = 0.
- **Read return:**
  - Registered rd_pend and rd_owner are set on a read grant.
  - Next cycle: the owner's rvalid = 1 and its rdata = mem_rdata. The other port's rdata is 0.
- Addresses pass through unchanged as word indices; no byte/word conversion.

## Timing
- Grant is combinational from req in the same cycle. The memory samples the command at the closing posedge.
- Read latency is 1 cycle: grant in cycle T, rvalid in T+1.
- Throughput is 1 access per cycle. A new grant may coincide with the rvalid of the previous read.
- Write completes at the posedge ending the grant cycle; there is no write acknowledge beyond gnt.
- Back-to-back read then write to the same address: the read returns old data.
- **Reset:**
  - All gnt/rvalid/mem_* outputs are 0 while rst is high.
  - State = ARB, starve_cnt = 0, rd_pend = 0.
- **Reset mid-operation:** a pending read is dropped with no rvalid. Requesters must re-issue after reset.
- **Simultaneous requests:** cpu wins unless starve_cnt == STARVE_MAX or state is LOCKED.
- A request deasserted before its grant is simply never served; no state is retained for it.

## Structure
- Shared parameters header holds:
  - DMEM_ADDR_W and DMEM_DATA_W (tied to WORD_SIZE)
  - Port IDs PORT_CPU = 0, PORT_DBG = 1
  - FSM encodings ARB_S = 0, LOCKED_S = 1
- One natural sub-module: `dmem_starve_cnt`, a saturating counter with inc/clr inputs and an `at_max` output.
- Top-level `dmem_arbiter` contains the FSM, the grant mux and the read-return register.

## Test plan
- **Reset:** rst pulse mid-read (cpu read granted in T, rst in T+1) -> cpu_rvalid never asserts; all outputs 0; first post-reset cpu_req is granted immediately.
- **CPU read:** cpu read at addr 5, memory holding 0xDEADBEEF -> cpu_gnt in T, mem_read = 1 with mem_addr = 5 in T, cpu_rvalid = 1 with cpu_rdata = 0xDEADBEEF in T+1, dbg_rvalid = 0.
- **Contention:** cpu_req and dbg_req held continuously, STARVE_MAX = 4 -> grant pattern cpu ×4, dbg ×1, repeating.
- **Lock:** dbg write with dbg_lock = 1, then cpu_req held and 3 dbg writes -> cpu_gnt stays 0 until the cycle after dbg_lock drops; all 4 dbg writes land at their addresses.
- **Pipelining:** back-to-back cpu reads at addr 1 and 2 (values 0x11 and 0x22) -> rvalid in consecutive cycles with data 0x11 then 0x22.
- **Interleaved ownership:** dbg read in T, cpu write in T+1 -> dbg_rvalid = 1 in T+1 with correct data; cpu_rvalid stays 0.
